rv64i_ins_loader: RTL

//  Write-side counterpart of the RV64I decoder. Accepts field-level instruction

---
 rtl/rv64i_pkg.sv | 43 ++++
 rtl/rv64i_enc_core.sv | 89 ++++++++
 rtl/rv64i_ins_loader.sv | 93 +++++++++
 3 files changed

// File: rtl/rv64i_pkg.sv
// Shared RV64I encoding constants: opcodes, op-class codes, funct3 codes.
// Used by both the instruction decoder and the instruction loader.
package rv64i_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [3:0] OP_RTYPE  = 4'd0;
    localparam logic [3:0] OP_ITYPE  = 4'd1;
    localparam logic [3:0] OP_LOAD   = 4'd2;
    localparam logic [3:0] OP_STORE  = 4'd3;
    localparam logic [3:0] OP_BRANCH = 4'd4;
    localparam logic [3:0] OP_LUI    = 4'd5;
    localparam logic [3:0] OP_AUIPC  = 4'd6;
    localparam logic [3:0] OP_JAL    = 4'd7;
    localparam logic [3:0] OP_JALR   = 4'd8;

    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_BR2  = 3'b010;
    localparam logic [2:0] F3_BR3  = 3'b011;
    localparam logic [2:0] F3_JALR = 3'b000;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_FULL = 1'b1
    } ld_state_e;

    // True when v, read as signed, is representable in n bits.
    function automatic logic fits_s(input logic [63:0] v, input int n);
        logic signed [63:0] t;
        t = $signed(v) >>> (n - 1);
        return (t == 64'sd0) || (t == -64'sd1);
    endfunction

endpackage

// File: rtl/rv64i_enc_core.sv
// Combinational field-to-word encoder for RV64I, flags illegal requests.
// Immediate range checking is compiled in with `define ENC_IMM_CHECK_EN.
module rv64i_enc_core
    import rv64i_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [2:0]  funct3,
    input  logic        alt,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [63:0] imm,
    output logic [31:0] word,
    output logic        illegal
);

    logic is_shift;
    logic op_bad;
    logic range_err;

    assign is_shift = (funct3 == F3_SLL) || (funct3 == F3_SR);

    always_comb begin
        word   = '0;
        op_bad = 1'b0;
        unique case (op)
            OP_RTYPE:
                word = {1'b0, alt, 5'b0, rs2, rs1, funct3, rd, OPC_OP};
            OP_ITYPE:
                if (is_shift)
                    word = {1'b0, alt, 4'b0, imm[5:0],
                            rs1, funct3, rd, OPC_OP_IMM};
                else
                    word = {imm[11:0], rs1, funct3, rd, OPC_OP_IMM};
            OP_LOAD:
                word = {imm[11:0], rs1, funct3, rd, OPC_LOAD};
            OP_STORE:
                word = {imm[11:5], rs2, rs1, funct3,
                        imm[4:0], OPC_STORE};
            OP_BRANCH: begin
                word = {imm[12], imm[10:5], rs2, rs1, funct3,
                        imm[4:1], imm[11], OPC_BRANCH};
                op_bad = (funct3 == F3_BR2) || (funct3 == F3_BR3);
            end
            OP_LUI:
                word = {imm[31:12], rd, OPC_LUI};
            OP_AUIPC:
                word = {imm[31:12], rd, OPC_AUIPC};
            OP_JAL:
                word = {imm[20], imm[10:1], imm[11], imm[19:12],
                        rd, OPC_JAL};
            OP_JALR:
                word = {imm[11:0], rs1, F3_JALR, rd, OPC_JALR};
            default:
                op_bad = 1'b1;
        endcase
    end

`ifdef ENC_IMM_CHECK_EN
    always_comb begin
        range_err = 1'b0;
        unique case (op)
            OP_ITYPE:
                if (is_shift)
                    range_err = (imm[63:6] != '0);
                else
                    range_err = !fits_s(imm, 12);
            OP_LOAD, OP_STORE, OP_JALR:
                range_err = !fits_s(imm, 12);
            OP_BRANCH:
                range_err = !fits_s(imm, 13) || imm[0];
            OP_JAL:
                range_err = !fits_s(imm, 21) || imm[0];
            OP_LUI, OP_AUIPC:
                range_err = (imm[11:0] != '0) || !fits_s(imm, 32);
            default:
                range_err = 1'b0;
        endcase
    end
`else
    // Out-of-field immediate bits are dropped silently.
    logic unused_imm;
    assign unused_imm = ^imm[63:32];
    assign range_err  = 1'b0;
`endif

    assign illegal = op_bad | range_err;

endmodule

// File: rtl/rv64i_ins_loader.sv
// Encodes field-level requests and writes them to imem at an incrementing pointer.
// Optional immediate range errors: `define ENC_IMM_CHECK_EN.
module rv64i_ins_loader
    import rv64i_pkg::*;
#(
    parameter int ADDR_W    = 9,
    parameter int DEPTH     = 512,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [2:0]        in_funct3,
    input  logic              in_alt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [63:0]       in_imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   wr_count,
    output logic              full,
    output logic              err,
    output logic              err_flag
);

    localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);

    ld_state_e         state;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W:0]   cnt_next;
    logic [31:0]       enc_word;
    logic              enc_illegal;
    logic              fire;

    rv64i_enc_core u_enc (
        .op      (in_op),
        .funct3  (in_funct3),
        .alt     (in_alt),
        .rd      (in_rd),
        .rs1     (in_rs1),
        .rs2     (in_rs2),
        .imm     (in_imm),
        .word    (enc_word),
        .illegal (enc_illegal)
    );

    assign in_ready = (state == ST_RUN) & ~clear;
    assign fire     = in_valid & in_ready;
    assign cnt_next = wr_count + 1'b1;
    assign full     = (wr_count == DEPTH_C);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_RUN;
            ptr        <= BASE;
            wr_count   <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            err        <= 1'b0;
            err_flag   <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            err     <= 1'b0;
            if (clear) begin
                state    <= ST_RUN;
                ptr      <= BASE;
                wr_count <= '0;
                err_flag <= 1'b0;
            end else if (fire) begin
                if (enc_illegal) begin
                    err      <= 1'b1;
                    err_flag <= 1'b1;
                end else begin
                    imem_we    <= 1'b1;
                    imem_addr  <= ptr;
                    imem_wdata <= enc_word;
                    ptr        <= ptr + 1'b1;
                    wr_count   <= cnt_next;
                    if (cnt_next == DEPTH_C)
                        state <= ST_FULL;
                end
            end
        end
    end

endmodule
